// File: rtl/vga_timing_tx.sv
// vga_timing_tx -- VGA transmitter for one fixed resolution.
// Produces hsync/vsync (active low) and 1-bit-per-channel RGB. Pixels are pulled
// from an upstream source over a valid/ready handshake, one per visible clock.
// The timing never stalls. A visible pixel with no valid data is sent black and
// is flagged on underflow.
//
// Ports:
//   clk         pixel clock
//   reset       asynchronous reset, active high
//   enable      1 = run timing, 0 = idle with counters cleared
//   pix_valid   upstream pixel available
//   pix_rgb     {r,g,b} of the upstream pixel
//   pix_ready   pixel accepted this cycle (combinational)
//   hsync/vsync sync outputs, active low, registered
//   r/g/b       colour outputs, registered
//   frame_start 1-cycle pulse with the output of position (0,0)
//   underflow   1-cycle pulse with a visible pixel that was sent black
//
// The counters hold the position being produced this cycle. Every output shows
// that position one clock later.
module vga_timing_tx #(
  parameter int BP_FIRST = 0,   // 0: VA,FP,PULSE,BP   1: BP,VA,FP,PULSE
  parameter int HVA      = 800,
  parameter int HFP      = 56,
  parameter int HP       = 120,
  parameter int HBP      = 64,
  parameter int VVA      = 600,
  parameter int VFP      = 37,
  parameter int VP       = 6,
  parameter int VBP      = 23,
  parameter int TP       = 0    // register delay of behavioural models; RTL is zero-delay
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       pix_valid,
  input  logic [2:0] pix_rgb,
  output logic       pix_ready,
  output logic       hsync,
  output logic       vsync,
  output logic       r,
  output logic       g,
  output logic       b,
  output logic       frame_start,
  output logic       underflow
);

  localparam int HTOTAL = HVA + HFP + HP + HBP;
  localparam int VTOTAL = VVA + VFP + VP + VBP;

  localparam logic [15:0] H_LAST = 16'(HTOTAL - 1);
  localparam logic [15:0] V_LAST = 16'(VTOTAL - 1);

  // Each region is described as a start position plus a length. Both line
  // orders then reduce to the same window test.
  localparam logic [15:0] H_VIS_LO = 16'((BP_FIRST != 0) ? HBP             : 0);
  localparam logic [15:0] H_SYN_LO = 16'((BP_FIRST != 0) ? HBP + HVA + HFP : HVA + HFP);
  localparam logic [15:0] V_VIS_LO = 16'((BP_FIRST != 0) ? VBP             : 0);
  localparam logic [15:0] V_SYN_LO = 16'((BP_FIRST != 0) ? VBP + VVA + VFP : VVA + VFP);
  localparam logic [15:0] H_VIS_W  = 16'(HVA);
  localparam logic [15:0] H_SYN_W  = 16'(HP);
  localparam logic [15:0] V_VIS_W  = 16'(VVA);
  localparam logic [15:0] V_SYN_W  = 16'(VP);

  // TP is meaningful only to delay-annotated simulation models. A negative
  // value is nonsensical, and this empty block makes the parameter visible
  // in the elaborated hierarchy.
  if (TP < 0) begin : g_tp_negative
  end

  logic [15:0] cnt_h, cnt_v;
  logic        h_vis, v_vis, h_pulse, v_pulse, xfer;

  // The test is (cnt - lo) < len, evaluated modulo 2^16. A position below lo
  // wraps to a large value and fails the test. This holds because both totals
  // fit in 16 bits.
  always_comb begin
    h_vis     = (cnt_h - H_VIS_LO) < H_VIS_W;
    v_vis     = (cnt_v - V_VIS_LO) < V_VIS_W;
    h_pulse   = (cnt_h - H_SYN_LO) < H_SYN_W;
    v_pulse   = (cnt_v - V_SYN_LO) < V_SYN_W;
    pix_ready = enable & h_vis & v_vis;
    xfer      = pix_ready & pix_valid;
  end

  // cnt_v only moves when cnt_h wraps. As a result, vsync can only change on a
  // line boundary.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_h <= '0;
      cnt_v <= '0;
    end else if (!enable) begin
      cnt_h <= '0;
      cnt_v <= '0;
    end else if (cnt_h == H_LAST) begin
      cnt_h <= '0;
      cnt_v <= (cnt_v == V_LAST) ? 16'd0 : cnt_v + 16'd1;
    end else begin
      cnt_h <= cnt_h + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      {r, g, b}   <= 3'b000;
      frame_start <= 1'b0;
      underflow   <= 1'b0;
    end else if (!enable) begin
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      {r, g, b}   <= 3'b000;
      frame_start <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      hsync       <= ~h_pulse;
      vsync       <= ~v_pulse;
      {r, g, b}   <= xfer ? pix_rgb : 3'b000;
      frame_start <= (cnt_h == 16'd0) && (cnt_v == 16'd0);
      underflow   <= pix_ready & ~pix_valid;
    end
  end

endmodule
